shared_mem_port_ctrl: RTL and testbench

- Sequences one single-port unified instruction/data memory between the IF stage (fetch at PCF) and the MEM stage (load/store described by the EX/MEM register outputs).
- Serialises the two requesters. The MEM stage has priority because it holds the older instruction.
- Generates a pipeline-wide stall plus a WB bubble until every access needed for the current cycle's instructions has completed.
- Sits between the core pipeline registers and the memory bus.

---
 rtl/mem_port_pkg.sv | 13 +
 rtl/shared_mem_port_timer.sv | 31 +++
 rtl/shared_mem_port_ctrl.sv | 148 ++++++++++++++
 tb/tb_shared_mem_port_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_pkg.sv
// Shared types and constants for the unified instruction/data memory port controller.
package mem_port_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DATA_WAIT  = 2'd1,
        INSTR_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/shared_mem_port_timer.sv
// Per-transaction wait timer: down-counter reloaded while idle, expiry at terminal count.
// Only built when MEM_PORT_TIMEOUT_EN is defined.
`ifdef MEM_PORT_TIMEOUT_EN
module shared_mem_port_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Loaded with TIMEOUT_CYCLES-1 so that terminal count lands on the last allowed wait cycle.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= LOAD;
        end else if (run && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = run & (count == '0);

endmodule
`endif

// File: rtl/shared_mem_port_ctrl.sv
// Serialises MEM-stage and IF-stage accesses onto one single-port memory and stalls the pipe.
// Optional bus timeout with NOP/zero substitution is enabled by MEM_PORT_TIMEOUT_EN.
//
// state      | meaning
// IDLE       | no transaction; pick data (priority) or fetch, else hold
// DATA_WAIT  | load/store outstanding, bus fields held stable until ack
// INSTR_WAIT | fetch of captured PCF outstanding until ack
module shared_mem_port_ctrl
    import mem_port_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCF,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic        MemWriteM,
    input  logic        MemReadM,
    output logic [31:0] InstrF,
    output logic [31:0] ReadDataM,
    output logic        PipeStall,
    output logic        BubbleW,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_err
);

    state_t          state;
    logic            instr_done;
    logic            data_done;
    logic [XLEN-1:0] instr_buf;
    logic [XLEN-1:0] data_buf;

    logic need_data;
    logic d_ack;
    logic i_ack;
    logic data_ok;
    logic instr_ok;
    logic advance;
    logic tmo;

    assign need_data = MemWriteM | MemReadM;
    assign d_ack     = (state == DATA_WAIT) & bus_ack;
    assign i_ack     = (state == INSTR_WAIT) & bus_ack;
    assign data_ok   = ~need_data | data_done | d_ack;
    assign instr_ok  = instr_done | i_ack;
    assign PipeStall = ~(data_ok & instr_ok);
    assign BubbleW   = PipeStall;
    assign advance   = ~PipeStall;

    // Ack-cycle bypass lets the pipeline advance in the same cycle the bus answers.
    assign InstrF    = i_ack ? bus_rdata : instr_buf;
    assign ReadDataM = d_ack ? bus_rdata : data_buf;

`ifdef MEM_PORT_TIMEOUT_EN
    shared_mem_port_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == IDLE),
        .run     (state != IDLE),
        .expired (tmo)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            instr_done <= 1'b0;
            data_done  <= 1'b0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_err    <= 1'b0;
            instr_buf  <= '0;
            data_buf   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (need_data && !data_done) begin
                        state     <= DATA_WAIT;
                        bus_req   <= 1'b1;
                        bus_we    <= MemWriteM;
                        bus_addr  <= ALUResultM;
                        bus_wdata <= WriteDataM;
                    end else if (!instr_done) begin
                        state    <= INSTR_WAIT;
                        bus_req  <= 1'b1;
                        bus_we   <= 1'b0;
                        bus_addr <= PCF;
                    end
                end
                DATA_WAIT: begin
                    if (bus_ack) begin
                        state     <= IDLE;
                        bus_req   <= 1'b0;
                        data_done <= 1'b1;
                        if (!bus_we) begin
                            data_buf <= bus_rdata;
                        end
                    end else if (tmo) begin
                        state     <= IDLE;
                        bus_req   <= 1'b0;
                        data_done <= 1'b1;
                        data_buf  <= '0;
                        bus_err   <= 1'b1;
                    end
                end
                INSTR_WAIT: begin
                    if (bus_ack) begin
                        state      <= IDLE;
                        bus_req    <= 1'b0;
                        instr_done <= 1'b1;
                        instr_buf  <= bus_rdata;
                    end else if (tmo) begin
                        state      <= IDLE;
                        bus_req    <= 1'b0;
                        instr_done <= 1'b1;
                        instr_buf  <= NOP_INSTR;
                        bus_err    <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    bus_req <= 1'b0;
                end
            endcase

            // The pipeline consumed this cycle's results; a same-cycle ack set is overridden.
            if (advance) begin
                instr_done <= 1'b0;
                data_done  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shared_mem_port_ctrl.sv
// Directed bench for shared_mem_port_ctrl with an expected-transaction scoreboard.
// Define MEM_PORT_TIMEOUT_EN to also exercise the timeout path (TIMEOUT_CYCLES=4).
module tb_shared_mem_port_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PCF, ALUResultM, WriteDataM;
    logic        MemWriteM, MemReadM;
    logic [31:0] InstrF, ReadDataM;
    logic        PipeStall, BubbleW;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        is_data;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    req_t exp_q[$];

    shared_mem_port_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .PCF        (PCF),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .MemWriteM  (MemWriteM),
        .MemReadM   (MemReadM),
        .InstrF     (InstrF),
        .ReadDataM  (ReadDataM),
        .PipeStall  (PipeStall),
        .BubbleW    (BubbleW),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic is_data, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata);
        req_t e;
        e.is_data = is_data;
        e.we      = we;
        e.addr    = addr;
        e.wdata   = wdata;
        exp_q.push_back(e);
    endtask

    // Waits for a request, matches it against the scoreboard, holds nwait cycles, then acks.
    task automatic serve(input int nwait, input logic [31:0] rdata, input int exp_idle,
                         input logic exp_stall_ack);
        int   cnt;
        req_t e;
        cnt = 0;
        while (!bus_req && cnt < 20) begin
            tick();
            cnt++;
        end
        chk("req_seen", {31'b0, bus_req}, 32'd1);
        if (exp_idle >= 0) chk("idle_cycles", cnt, exp_idle);
        if (exp_q.size() == 0) begin
            chk("scoreboard_nonempty", 32'd0, 32'd1);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        chk("req_we", {31'b0, bus_we}, {31'b0, e.we});
        chk("req_addr", bus_addr, e.addr);
        if (e.we) chk("req_wdata", bus_wdata, e.wdata);
        for (int i = 0; i < nwait; i++) begin
            chk("wait_stall", {31'b0, PipeStall}, 32'd1);
            tick();
            chk("hold_req", {31'b0, bus_req}, 32'd1);
            chk("hold_addr", bus_addr, e.addr);
            chk("hold_we", {31'b0, bus_we}, {31'b0, e.we});
            if (e.we) chk("hold_wdata", bus_wdata, e.wdata);
        end
        bus_ack   = 1'b1;
        bus_rdata = rdata;
        #1;
        if (!e.is_data)  chk("instr_bypass", InstrF, rdata);
        else if (!e.we)  chk("load_bypass", ReadDataM, rdata);
        chk("ack_stall", {31'b0, PipeStall}, {31'b0, exp_stall_ack});
        chk("ack_bubble", {31'b0, BubbleW}, {31'b0, exp_stall_ack});
        tick();
        bus_ack   = 1'b0;
        bus_rdata = $urandom;
        chk("req_dropped", {31'b0, bus_req}, 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        PCF        = '0;
        ALUResultM = '0;
        WriteDataM = '0;
        MemWriteM  = 1'b0;
        MemReadM   = 1'b0;
        bus_ack    = 1'b0;
        bus_rdata  = '0;
        repeat (3) tick();

        chk("rst_req", {31'b0, bus_req}, 32'd0);
        chk("rst_we", {31'b0, bus_we}, 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_err", {31'b0, bus_err}, 32'd0);
        chk("rst_stall", {31'b0, PipeStall}, 32'd1);
        chk("rst_bubble", {31'b0, BubbleW}, 32'd1);
        chk("rst_instr", InstrF, 32'd0);
        chk("rst_rdata", ReadDataM, 32'd0);

        // Fetch only, one wait cycle before ack
        PCF   = 32'h40;
        reset = 1'b0;
        push(1'b0, 1'b0, 32'h40, 32'h0);
        #1;
        chk("c0_stall", {31'b0, PipeStall}, 32'd1);
        serve(1, 32'h0050_0093, 1, 1'b0);
        chk("instr_held", InstrF, 32'h0050_0093);

        // Load then fetch: data has priority
        PCF        = 32'h44;
        MemReadM   = 1'b1;
        ALUResultM = 32'h100;
        push(1'b1, 1'b0, 32'h100, 32'h0);
        push(1'b0, 1'b0, 32'h44, 32'h0);
        serve(0, 32'hDEAD_BEEF, 1, 1'b1);
        chk("load_held", ReadDataM, 32'hDEAD_BEEF);
        chk("load_stall_between", {31'b0, PipeStall}, 32'd1);
        serve(0, 32'h00A0_0113, 1, 1'b0);
        chk("load_after_fetch", ReadDataM, 32'hDEAD_BEEF);

        // Store (read also asserted) with three wait cycles, then fetch
        PCF        = 32'h48;
        MemWriteM  = 1'b1;
        ALUResultM = 32'h200;
        WriteDataM = 32'hCAFE_F00D;
        push(1'b1, 1'b1, 32'h200, 32'hCAFE_F00D);
        push(1'b0, 1'b0, 32'h48, 32'h0);
        serve(3, 32'h1234_5678, 1, 1'b1);
        serve(0, 32'h00B0_0193, 1, 1'b0);
        chk("store_keeps_dbuf", ReadDataM, 32'hDEAD_BEEF);
        MemWriteM = 1'b0;
        MemReadM  = 1'b0;

        // Reset during DATA_WAIT followed by a spurious ack
        PCF        = 32'h4C;
        MemReadM   = 1'b1;
        ALUResultM = 32'h300;
        tick();
        chk("rw_req", {31'b0, bus_req}, 32'd1);
        chk("rw_addr", bus_addr, 32'h300);
        reset = 1'b1;
        tick();
        chk("rw_req_drop", {31'b0, bus_req}, 32'd0);
        reset     = 1'b0;
        MemReadM  = 1'b0;
        PCF       = 32'h80;
        bus_ack   = 1'b1;
        bus_rdata = 32'hBAD0_BAD0;
        #1;
        chk("spur_instr", InstrF, 32'd0);
        chk("spur_rdata", ReadDataM, 32'd0);
        chk("spur_stall", {31'b0, PipeStall}, 32'd1);
        tick();
        bus_ack = 1'b0;
        push(1'b0, 1'b0, 32'h80, 32'h0);
        serve(0, 32'h0100_0093, 0, 1'b0);

        // Back-to-back zero-wait fetches
        for (int k = 0; k < 4; k++) begin
            PCF = 32'h100 + 32'(4 * k);
            push(1'b0, 1'b0, PCF, 32'h0);
            serve(0, 32'h0010_0013 + 32'(k << 7), 1, 1'b0);
        end
        chk("err_default", {31'b0, bus_err}, 32'd0);

`ifdef MEM_PORT_TIMEOUT_EN
        PCF = 32'hC0;
        tick();
        chk("tmo_req", {31'b0, bus_req}, 32'd1);
        chk("tmo_addr", bus_addr, 32'hC0);
        for (int i = 0; i < 3; i++) begin
            chk("tmo_err_early", {31'b0, bus_err}, 32'd0);
            tick();
        end
        chk("tmo_req_last", {31'b0, bus_req}, 32'd1);
        chk("tmo_err_last", {31'b0, bus_err}, 32'd0);
        tick();
        chk("tmo_req_drop", {31'b0, bus_req}, 32'd0);
        chk("tmo_err", {31'b0, bus_err}, 32'd1);
        chk("tmo_nop", InstrF, 32'h0000_0013);
        chk("tmo_stall", {31'b0, PipeStall}, 32'd0);
        PCF = 32'hC4;
        push(1'b0, 1'b0, 32'hC4, 32'h0);
        serve(0, 32'h0020_0013, 2, 1'b0);
        chk("tmo_err_sticky", {31'b0, bus_err}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("tmo_err_clear", {31'b0, bus_err}, 32'd0);
`endif

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
